// File: rtl/tcpc_bus_master_pkg.sv
// Shared definitions for the TCPC register-bus initiator: FSM states,
// counter width, TCPC register addresses and the burst address-step helper.
package tcpc_bus_master_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    localparam logic [7:0] REG_ALERT                = 8'h10;
    localparam logic [7:0] REG_ALERT_MASK           = 8'h12;
    localparam logic [7:0] REG_RX_BUF_HEADER_BYTE_0 = 8'h32;
    localparam logic [7:0] REG_TRANSMIT             = 8'h50;

    function automatic logic [7:0] next_addr(input logic [7:0] addr, input logic inc);
        return addr + (inc ? 8'd2 : 8'd1);
    endfunction

endpackage

// File: rtl/tcpc_timeout_ctr.sv
// Clear/enable counter with a terminal-count flag; saturates at TC.
// Used for the ACK wait timer and for counting retry attempts.
module tcpc_timeout_ctr
    import tcpc_bus_master_pkg::*;
#(
    parameter logic [CNT_W-1:0] TC = '1
) (
    input  logic clk,
    input  logic reset_L,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != TC)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC);

endmodule

// File: rtl/tcpc_bus_master.sv
// TCPM-side initiator for the TCPC register bus: command in, one bus beat per
// register, one response per beat. Optional retry on ACK timeout: TCPM_RETRY_EN.
module tcpc_bus_master
    import tcpc_bus_master_pkg::*;
#(
    parameter int TIMEOUT_CYC = 15,
    parameter int RETRIES     = 2
) (
    input  logic        clk,
    input  logic        reset_L,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rnw,
    input  logic [7:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    input  logic [3:0]  cmd_len,
    input  logic        cmd_inc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        rsp_last,
    output logic        req,
    output logic [7:0]  ADDR,
    output logic        RNW,
    output logic [15:0] WR_DATA,
    input  logic [15:0] RD_DATA,
    input  logic        ACK
);

`ifdef TCPM_RETRY_EN
    localparam bit RETRY_ON = 1'b1;
`else
    localparam bit RETRY_ON = 1'b0;
`endif

    state_e      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_last_q, rsp_last_d;
    logic        req_q, req_d;
    logic [7:0]  addr_q, addr_d;
    logic        rnw_q, rnw_d;
    logic [15:0] wdata_q, wdata_d;
    logic [3:0]  beats_q, beats_d;
    logic        inc_q, inc_d;

    logic ack_hit;
    logic wait_tc;
    logic retry_tc;
    logic retry_final;
    logic timeout;

    // ACK may idle high from the slave; it only counts while we are requesting.
    assign ack_hit     = ACK && req_q;
    assign timeout     = (state_q == ST_REQ) && !ack_hit && wait_tc;
    assign retry_final = retry_tc || !RETRY_ON;

    tcpc_timeout_ctr #(
        .TC(CNT_W'(TIMEOUT_CYC - 1))
    ) u_wait_ctr (
        .clk    (clk),
        .reset_L(reset_L),
        .clr_i  (state_q != ST_REQ),
        .en_i   ((state_q == ST_REQ) && !ack_hit),
        .tc_o   (wait_tc)
    );

    // Cleared between beats, so each beat gets its own set of retries.
    tcpc_timeout_ctr #(
        .TC(CNT_W'(RETRIES))
    ) u_retry_ctr (
        .clk    (clk),
        .reset_L(reset_L),
        .clr_i  ((state_q == ST_IDLE) || (state_q == ST_RSP)),
        .en_i   (timeout && !retry_final),
        .tc_o   (retry_tc)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rnw_d      = rnw_q;
        wdata_d    = wdata_q;
        beats_d    = beats_q;
        inc_d      = inc_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        rsp_last_d = rsp_last_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d  = cmd_addr;
                    rnw_d   = cmd_rnw;
                    wdata_d = cmd_wdata;
                    inc_d   = cmd_inc;
                    beats_d = (!cmd_rnw || (cmd_len == 4'd0)) ? 4'd1 : cmd_len;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_hit) begin
                    rsp_data_d = rnw_q ? RD_DATA : 16'h0000;
                    rsp_err_d  = 1'b0;
                    rsp_last_d = (beats_q == 4'd1);
                    state_d    = ST_RSP;
                end else if (timeout) begin
                    if (retry_final) begin
                        rsp_data_d = 16'h0000;
                        rsp_err_d  = 1'b1;
                        rsp_last_d = 1'b1;
                        state_d    = ST_RSP;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                state_d = ST_REQ;
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_data_d = 16'h0000;
                    rsp_err_d  = 1'b0;
                    rsp_last_d = 1'b0;
                    if (!rsp_err_q && (beats_q > 4'd1)) begin
                        beats_d = beats_q - 4'd1;
                        addr_d  = next_addr(addr_q, inc_q);
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake outputs are registered copies of the next state.
        req_d       = (state_d == ST_REQ);
        rsp_valid_d = (state_d == ST_RSP);
        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'h0000;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
            req_q       <= 1'b0;
            addr_q      <= 8'h00;
            rnw_q       <= 1'b1;
            wdata_q     <= 16'h0000;
            beats_q     <= 4'd0;
            inc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_last_q  <= rsp_last_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            rnw_q       <= rnw_d;
            wdata_q     <= wdata_d;
            beats_q     <= beats_d;
            inc_q       <= inc_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_last  = rsp_last_q;
    assign req       = req_q;
    assign ADDR      = addr_q;
    assign RNW       = rnw_q;
    assign WR_DATA   = wdata_q;

endmodule

// File: tb/tb_tcpc_bus_master.sv
// Directed bench for tcpc_bus_master: the bench plays the policy engine and a
// TCPC slave with configurable ACK latency. Expected values are hand-computed.
module tb_tcpc_bus_master;
    import tcpc_bus_master_pkg::*;

`ifdef TCPM_RETRY_EN
    localparam int NWIN = 3;
`else
    localparam int NWIN = 1;
`endif
    localparam int NEVER = -1;

    logic        clk = 1'b0;
    logic        reset_L;
    logic        cmd_valid, cmd_ready, cmd_rnw, cmd_inc;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic [3:0]  cmd_len;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_last;
    logic [15:0] rsp_data;
    logic        req, RNW, ACK;
    logic [7:0]  ADDR;
    logic [15:0] WR_DATA, RD_DATA;

    int n_checks = 0;
    int n_fail   = 0;

    int          ack_wait = 0;
    logic [15:0] rd_base  = 16'h0000;
    bit          linger_en = 1'b0;
    int          req_run  = 0;
    bit          last_acked = 1'b0;

    logic [7:0]  w_addr[$];
    logic        w_rnw[$];
    logic [15:0] w_wd[$];
    int          w_len[$];
    int          w_gap[$];
    int          run_len = 0;
    int          low_run = 0;
    logic        req_prev = 1'b0;
    int          overlap_cnt = 0;
    int          unstable_cnt = 0;

    tcpc_bus_master dut (
        .clk      (clk),
        .reset_L  (reset_L),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_rnw  (cmd_rnw),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_len  (cmd_len),
        .cmd_inc  (cmd_inc),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .rsp_last (rsp_last),
        .req      (req),
        .ADDR     (ADDR),
        .RNW      (RNW),
        .WR_DATA  (WR_DATA),
        .RD_DATA  (RD_DATA),
        .ACK      (ACK)
    );

    always #5 clk = ~clk;

    // Slave: ACK after ack_wait cycles of req; optionally leaves ACK high one cycle after req drops.
    always @(negedge clk) begin
        if (req) begin
            ACK = (ack_wait >= 0) && (req_run >= ack_wait);
            req_run++;
        end else begin
            ACK = linger_en && last_acked;
            req_run = 0;
        end
        RD_DATA = ACK ? (rd_base ^ {8'h00, ADDR}) : 16'hDEAD;
        last_acked = req && ACK;
    end

    // Bus monitor: records every req window and its preceding idle gap.
    always @(negedge clk) begin
        if (req && !req_prev) begin
            w_addr.push_back(ADDR);
            w_rnw.push_back(RNW);
            w_wd.push_back(WR_DATA);
            w_gap.push_back(low_run);
            run_len = 1;
            low_run = 0;
        end else if (req) begin
            run_len++;
            if (ADDR != w_addr[$] || RNW != w_rnw[$] || WR_DATA != w_wd[$]) unstable_cnt++;
        end else begin
            if (req_prev) w_len.push_back(run_len);
            low_run++;
        end
        if (req && rsp_valid) overlap_cnt++;
        req_prev = req;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic rnw, input logic [7:0] addr, input logic [15:0] wdata,
                            input logic [3:0] len, input logic inc);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_rnw   = rnw;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_len   = len;
        cmd_inc   = inc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input int stall, output logic [15:0] d, output logic e, output logic l);
        int n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rsp_valid_wait", rsp_valid, 1);
        repeat (stall) begin
            @(negedge clk);
            check("stall_valid", rsp_valid, 1);
            check("stall_req", req, 0);
        end
        d = rsp_data;
        e = rsp_err;
        l = rsp_last;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    logic [15:0] d;
    logic        e, l;
    int          base;
    bit          seen;
    logic [15:0] exp_burst[4] = '{16'hA530, 16'hA531, 16'hA532, 16'hA533};
    logic [7:0]  exp_wrap[3]  = '{8'hFE, 8'hFF, 8'h00};
    logic [15:0] exp_wrapd[3] = '{16'h5AFE, 16'h5AFF, 16'h5A00};

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset_L = 1'b0; cmd_valid = 1'b0; cmd_rnw = 1'b1; cmd_addr = 8'h00;
        cmd_wdata = 16'h0000; cmd_len = 4'd1; cmd_inc = 1'b0; rsp_ready = 1'b0;
        ACK = 1'b0; RD_DATA = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_req", req, 0);
        check("rst_addr", ADDR, 8'h00);
        check("rst_rnw", RNW, 1);
        check("rst_wdata", WR_DATA, 16'h0000);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 16'h0000);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_last", rsp_last, 0);
        reset_L = 1'b1;
        @(negedge clk);
        check("ready_after_rst", cmd_ready, 1);

        // 1: zero-wait read, exact latency
        ack_wait = 0; rd_base = 16'h1234; base = w_len.size();
        send_cmd(1'b1, 8'h00, 16'h0000, 4'd1, 1'b0);
        check("t1_req_c1", req, 1);
        check("t1_addr", ADDR, 8'h00);
        check("t1_rnw", RNW, 1);
        check("t1_ready_busy", cmd_ready, 0);
        @(negedge clk);
        check("t1_req_c2", req, 0);
        check("t1_valid_c2", rsp_valid, 1);
        get_rsp(0, d, e, l);
        check("t1_data", d, 16'h1234);
        check("t1_err", e, 0);
        check("t1_last", l, 1);
        check("t1_win_len", w_len[base], 1);
        check("t1_ready_back", cmd_ready, 1);

        // 2: write, len ignored, one-wait ACK
        ack_wait = 1; rd_base = 16'hBEEF; base = w_len.size();
        send_cmd(1'b0, REG_ALERT_MASK, 16'h00FF, 4'd5, 1'b0);
        get_rsp(0, d, e, l);
        check("t2_data", d, 16'h0000);
        check("t2_err", e, 0);
        check("t2_last", l, 1);
        check("t2_nwin", w_len.size() - base, 1);
        check("t2_addr", w_addr[base], 8'h12);
        check("t2_rnw", w_rnw[base], 0);
        check("t2_wdata", w_wd[base], 16'h00FF);
        check("t2_win_len", w_len[base], 2);

        // 3: 4-beat burst, stall on beat 2, ACK lingering after req drops
        ack_wait = 2; rd_base = 16'hA500; linger_en = 1'b1; base = w_len.size();
        send_cmd(1'b1, 8'h30, 16'h0000, 4'd4, 1'b0);
        for (int b = 0; b < 4; b++) begin
            get_rsp((b == 1) ? 3 : 0, d, e, l);
            check($sformatf("t3_data%0d", b), d, exp_burst[b]);
            check($sformatf("t3_err%0d", b), e, 0);
            check($sformatf("t3_last%0d", b), l, (b == 3) ? 1 : 0);
        end
        linger_en = 1'b0;
        check("t3_nwin", w_len.size() - base, 4);
        for (int b = 0; b < 4; b++) begin
            check($sformatf("t3_addr%0d", b), w_addr[base + b], 8'h30 + 8'(b));
            check($sformatf("t3_len%0d", b), w_len[base + b], 3);
        end

        // 3b: +2 stride and len=0 treated as one beat
        ack_wait = 0; rd_base = 16'h0F00; base = w_len.size();
        send_cmd(1'b1, REG_ALERT, 16'h0000, 4'd2, 1'b1);
        get_rsp(0, d, e, l);
        check("t3b_data0", d, 16'h0F10);
        check("t3b_last0", l, 0);
        get_rsp(0, d, e, l);
        check("t3b_data1", d, 16'h0F12);
        check("t3b_last1", l, 1);
        check("t3b_addr1", w_addr[base + 1], 8'h12);
        base = w_len.size();
        send_cmd(1'b1, REG_TRANSMIT, 16'h0000, 4'd0, 1'b0);
        get_rsp(0, d, e, l);
        check("t3c_data", d, 16'h0F50);
        check("t3c_last", l, 1);
        check("t3c_nwin", w_len.size() - base, 1);

        // 4/5: slave never ACKs; remaining beats of a 3-beat read are dropped
        ack_wait = NEVER; base = w_len.size();
        send_cmd(1'b1, 8'h20, 16'h0000, 4'd3, 1'b0);
        get_rsp(0, d, e, l);
        check("t4_data", d, 16'h0000);
        check("t4_err", e, 1);
        check("t4_last", l, 1);
        repeat (4) @(negedge clk);
        check("t4_no_more_rsp", rsp_valid, 0);
        check("t4_idle_ready", cmd_ready, 1);
        check("t4_nwin", w_len.size() - base, NWIN);
        for (int i = 0; i < NWIN; i++) begin
            check($sformatf("t4_len%0d", i), w_len[base + i], 15);
            check($sformatf("t4_addr%0d", i), w_addr[base + i], 8'h20);
            if (i > 0) check($sformatf("t4_gap%0d", i), w_gap[base + i], 1);
        end

        // 6: address wrap, then reset mid-REQ and recovery
        ack_wait = 0; rd_base = 16'h5A00; base = w_len.size();
        send_cmd(1'b1, 8'hFE, 16'h0000, 4'd3, 1'b0);
        for (int b = 0; b < 3; b++) begin
            get_rsp(0, d, e, l);
            check($sformatf("t6_data%0d", b), d, exp_wrapd[b]);
            check($sformatf("t6_last%0d", b), l, (b == 2) ? 1 : 0);
            check($sformatf("t6_addr%0d", b), w_addr[base + b], exp_wrap[b]);
        end
        ack_wait = NEVER;
        send_cmd(1'b1, 8'h40, 16'h0000, 4'd1, 1'b0);
        repeat (2) @(negedge clk);
        check("t6_pre_rst_req", req, 1);
        reset_L = 1'b0;
        #1;
        check("t6_rst_req_async", req, 0);
        check("t6_rst_valid", rsp_valid, 0);
        @(negedge clk);
        reset_L = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("t6_no_rsp_after_rst", seen, 0);
        check("t6_ready_after_rst", cmd_ready, 1);
        ack_wait = 0; rd_base = 16'h7700; base = w_len.size();
        send_cmd(1'b1, REG_RX_BUF_HEADER_BYTE_0, 16'h0000, 4'd1, 1'b0);
        get_rsp(0, d, e, l);
        check("t6_rec_data", d, 16'h7732);
        check("t6_rec_err", e, 0);
        check("t6_rec_last", l, 1);
        check("t6_rec_addr", w_addr[base], 8'h32);

        check("req_during_rsp", overlap_cnt, 0);
        check("bus_unstable", unstable_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
